// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: turns SPI words from spi_slave into register-bank bursts.
// The first word of each chip-select frame is a command: bit WIDTH-1 selects
// read (1) or write (0), and the low ADDR_WIDTH bits give the start address.
// Write bursts strobe reg_we once per data word. Read bursts fetch a register,
// load it into the slave tx path, then prefetch the next register when the
// host clocks out the following dummy word.
module spi_reg_ctrl #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ss,
  input  logic [WIDTH-1:0]      rx_data,
  input  logic                  rx_dv,
  output logic [WIDTH-1:0]      tx_data,
  output logic                  tx_wr,
  input  logic                  tx_halt,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [WIDTH-1:0]      reg_wdata,
  output logic                  reg_we,
  output logic                  reg_re,
  input  logic [WIDTH-1:0]      reg_rdata,
  output logic                  busy,
  output logic                  ovr_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    WDATA   = 3'd2,
    RD_REQ  = 3'd3,
    RD_LOAD = 3'd4,
    RD_WAIT = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]        tx_data_q, tx_data_d;
  logic                    tx_wr_q, tx_wr_d;
  logic                    ss_meta_q, ss_s_q;

  // Two-flop synchroniser for the raw chip select; resets to deselected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_meta_q <= 1'b1;
      ss_s_q    <= 1'b1;
    end else begin
      ss_meta_q <= ss;
      ss_s_q    <= ss_meta_q;
    end
  end

  // State, address counter and registered tx load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      tx_data_q <= '0;
      tx_wr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      tx_data_q <= tx_data_d;
      tx_wr_q   <= tx_wr_d;
    end
  end

  // Next-state logic and bus strobes; a deselected frame overrides everything,
  // so no strobe can fire in the cycle the frame is torn down.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    tx_data_d = tx_data_q;
    tx_wr_d   = 1'b0;
    reg_we    = 1'b0;
    reg_re    = 1'b0;
    reg_wdata = '0;
    ovr_err   = 1'b0;
    if (ss_s_q) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = CMD;
        CMD: begin
          if (rx_dv) begin
            addr_d  = rx_data[ADDR_WIDTH-1:0];
            state_d = rx_data[WIDTH-1] ? RD_REQ : WDATA;
          end
        end
        WDATA: begin
          if (rx_dv) begin
            reg_we    = 1'b1;
            reg_wdata = rx_data;
            addr_d    = addr_q + ADDR_ONE;
          end
        end
        RD_REQ: begin
          // A word arriving before the fetched data reached the tx path is dropped.
          ovr_err = rx_dv;
          reg_re  = 1'b1;
          state_d = RD_LOAD;
        end
        RD_LOAD: begin
          ovr_err = rx_dv;
          // reg_addr is held here, so reg_rdata stays valid while tx is busy.
          if (!tx_halt) begin
            tx_data_d = reg_rdata;
            tx_wr_d   = 1'b1;
            addr_d    = addr_q + ADDR_ONE;
            state_d   = RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rx_dv) begin
            state_d = RD_REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign reg_addr = addr_q;
  assign tx_data  = tx_data_q;
  assign tx_wr    = tx_wr_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl with a small register-bank model.
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ss;
  logic [7:0] rx_data;
  logic       rx_dv;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_halt;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       ovr_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] regs [128];
  logic [6:0] we_addr_q [$];
  logic [7:0] we_data_q [$];
  logic [6:0] re_addr_q [$];
  logic [7:0] tx_q [$];
  int         ovr_cnt = 0;
  int         viol    = 0;

  spi_reg_ctrl #(.WIDTH(8), .ADDR_WIDTH(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .ss        (ss),
    .rx_data   (rx_data),
    .rx_dv     (rx_dv),
    .tx_data   (tx_data),
    .tx_wr     (tx_wr),
    .tx_halt   (tx_halt),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .ovr_err   (ovr_err)
  );

  always #5 clk = ~clk;

  // Register bank: read data valid the cycle after reg_re.
  always @(posedge clk) begin
    if (reg_re) reg_rdata <= regs[reg_addr];
    if (reg_we) regs[reg_addr] <= reg_wdata;
  end

  // Transaction monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (reg_we) begin
        we_addr_q.push_back(reg_addr);
        we_data_q.push_back(reg_wdata);
        $display("[%0t] reg write addr=%02h data=%02h", $time, reg_addr, reg_wdata);
      end
      if (reg_re) begin
        re_addr_q.push_back(reg_addr);
        $display("[%0t] reg read  addr=%02h", $time, reg_addr);
      end
      if (tx_wr) begin
        tx_q.push_back(tx_data);
        $display("[%0t] tx load   data=%02h", $time, tx_data);
      end
      if (ovr_err) begin
        ovr_cnt++;
        $display("[%0t] overrun pulse", $time);
      end
      if (reg_we && reg_re) viol++;
      if (tx_wr && tx_halt) viol++;
    end
  end

  task automatic clear_logs();
    we_addr_q.delete();
    we_data_q.delete();
    re_addr_q.delete();
    tx_q.delete();
    ovr_cnt = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ss_low();
    @(posedge clk); #1 ss = 1'b0;
    cycles(4);
  endtask

  task automatic ss_high();
    @(posedge clk); #1 ss = 1'b1;
    cycles(4);
  endtask

  task automatic send_word(input logic [7:0] w);
    @(posedge clk); #1;
    rx_data = w;
    rx_dv   = 1'b1;
    @(posedge clk); #1;
    rx_dv   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; ss = 1'b1; rx_dv = 1'b1; rx_data = 8'hFF; tx_halt = 1'b0;
    cycles(3);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (reg_we !== 1'b0 || reg_re !== 1'b0 || tx_wr !== 1'b0 || ovr_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_strobes got we=%b re=%b txwr=%b ovr=%b exp=0", reg_we, reg_re, tx_wr, ovr_err); end
    n_checks++; if (reg_addr !== 7'h00 || reg_wdata !== 8'h00 || tx_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_data got addr=%h wdata=%h tx=%h exp=0", reg_addr, reg_wdata, tx_data); end
    rx_dv = 1'b0; rx_data = 8'h00;
    @(posedge clk); #1 rst = 1'b1;
    cycles(2);
  endtask

  task automatic test_write_burst();
    clear_logs();
    ss_low();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_sel got=%b exp=1", busy); end
    send_word(8'h05); cycles(4);
    send_word(8'hA1); cycles(4);
    send_word(8'hB2); cycles(4);
    send_word(8'hC3); cycles(4);
    ss_high();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_desel got=%b exp=0", busy); end
    n_checks++; if (we_addr_q.size() != 3) begin n_fail++; $display("FAIL wr_count got=%0d exp=3", we_addr_q.size()); end
    else begin
      n_checks++; if (we_addr_q[0] !== 7'h05 || we_addr_q[1] !== 7'h06 || we_addr_q[2] !== 7'h07) begin
        n_fail++; $display("FAIL wr_addr got=%h,%h,%h exp=05,06,07", we_addr_q[0], we_addr_q[1], we_addr_q[2]); end
      n_checks++; if (we_data_q[0] !== 8'hA1 || we_data_q[1] !== 8'hB2 || we_data_q[2] !== 8'hC3) begin
        n_fail++; $display("FAIL wr_data got=%h,%h,%h exp=A1,B2,C3", we_data_q[0], we_data_q[1], we_data_q[2]); end
    end
    n_checks++; if (regs[7] !== 8'hC3) begin n_fail++; $display("FAIL wr_bank got=%h exp=C3", regs[7]); end
  endtask

  task automatic test_read_burst();
    clear_logs();
    regs[16] = 8'h11; regs[17] = 8'h22; regs[18] = 8'h33; regs[19] = 8'h44;
    ss_low();
    send_word(8'h90);
    @(negedge clk);
    n_checks++; if (reg_re !== 1'b1 || reg_addr !== 7'h10) begin
      n_fail++; $display("FAIL rd_first_re got re=%b addr=%h exp re=1 addr=10", reg_re, reg_addr); end
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (tx_wr !== 1'b1 || tx_data !== 8'h11) begin
      n_fail++; $display("FAIL rd_latency got txwr=%b data=%h exp txwr=1 data=11", tx_wr, tx_data); end
    cycles(6);
    send_word(8'h00); cycles(8);
    send_word(8'h00); cycles(8);
    send_word(8'h00); cycles(8);
    ss_high();
    n_checks++; if (re_addr_q.size() != 4) begin n_fail++; $display("FAIL rd_re_count got=%0d exp=4", re_addr_q.size()); end
    else begin
      n_checks++; if (re_addr_q[0] !== 7'h10 || re_addr_q[1] !== 7'h11 || re_addr_q[2] !== 7'h12 || re_addr_q[3] !== 7'h13) begin
        n_fail++; $display("FAIL rd_re_addr got=%h,%h,%h,%h exp=10,11,12,13", re_addr_q[0], re_addr_q[1], re_addr_q[2], re_addr_q[3]); end
    end
    n_checks++; if (tx_q.size() < 3) begin n_fail++; $display("FAIL rd_tx_count got=%0d exp>=3", tx_q.size()); end
    else begin
      n_checks++; if (tx_q[0] !== 8'h11 || tx_q[1] !== 8'h22 || tx_q[2] !== 8'h33) begin
        n_fail++; $display("FAIL rd_tx_data got=%h,%h,%h exp=11,22,33", tx_q[0], tx_q[1], tx_q[2]); end
    end
    n_checks++; if (ovr_cnt != 0) begin n_fail++; $display("FAIL rd_no_ovr got=%0d exp=0", ovr_cnt); end
  endtask

  task automatic test_wrap();
    clear_logs();
    ss_low();
    send_word(8'h7F); cycles(4);
    send_word(8'hAA); cycles(4);
    send_word(8'hBB); cycles(4);
    ss_high();
    n_checks++; if (we_addr_q.size() != 2) begin n_fail++; $display("FAIL wrap_count got=%0d exp=2", we_addr_q.size()); end
    else begin
      n_checks++; if (we_addr_q[0] !== 7'h7F || we_addr_q[1] !== 7'h00 || we_data_q[0] !== 8'hAA || we_data_q[1] !== 8'hBB) begin
        n_fail++; $display("FAIL wrap_seq got=%h:%h,%h:%h exp=7F:AA,00:BB", we_addr_q[0], we_data_q[0], we_addr_q[1], we_data_q[1]); end
    end
  endtask

  task automatic test_abort();
    clear_logs();
    ss_low();
    send_word(8'h20); cycles(4);
    send_word(8'h01); cycles(4);
    send_word(8'h02); cycles(2);
    ss_high();
    send_word(8'h03); cycles(4);
    n_checks++; if (we_addr_q.size() != 2) begin n_fail++; $display("FAIL abort_count got=%0d exp=2", we_addr_q.size()); end
    else begin
      n_checks++; if (we_addr_q[0] !== 7'h20 || we_addr_q[1] !== 7'h21) begin
        n_fail++; $display("FAIL abort_addr got=%h,%h exp=20,21", we_addr_q[0], we_addr_q[1]); end
    end
    clear_logs();
    ss_low();
    send_word(8'h03); cycles(4);
    send_word(8'h5A); cycles(4);
    ss_high();
    n_checks++; if (we_addr_q.size() != 1) begin n_fail++; $display("FAIL abort_next_count got=%0d exp=1", we_addr_q.size()); end
    else begin
      n_checks++; if (we_addr_q[0] !== 7'h03 || we_data_q[0] !== 8'h5A) begin
        n_fail++; $display("FAIL abort_next got=%h:%h exp=03:5A", we_addr_q[0], we_data_q[0]); end
    end
  endtask

  task automatic test_overrun_halt();
    bit seen;
    clear_logs();
    regs[48] = 8'h77;
    tx_halt = 1'b1;
    ss_low();
    send_word(8'hB0);
    @(posedge clk); #1;
    rx_data = 8'hEE; rx_dv = 1'b1;
    @(negedge clk);
    n_checks++; if (ovr_err !== 1'b1 || tx_wr !== 1'b0) begin
      n_fail++; $display("FAIL ovr_pulse got ovr=%b txwr=%b exp ovr=1 txwr=0", ovr_err, tx_wr); end
    @(posedge clk); #1 rx_dv = 1'b0;
    @(negedge clk);
    n_checks++; if (ovr_err !== 1'b0) begin n_fail++; $display("FAIL ovr_one_cycle got=%b exp=0", ovr_err); end
    cycles(5);
    n_checks++; if (tx_q.size() != 0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL halt_hold got txloads=%0d busy=%b exp txloads=0 busy=1", tx_q.size(), busy); end
    tx_halt = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (tx_wr) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL halt_release_tx got=none exp=tx_wr within 10 cycles"); end
    else begin
      n_checks++; if (tx_data !== 8'h77) begin n_fail++; $display("FAIL halt_tx_data got=%h exp=77", tx_data); end
    end
    ss_high();
    n_checks++; if (ovr_cnt != 1 || we_addr_q.size() != 0) begin
      n_fail++; $display("FAIL ovr_total got ovr=%0d writes=%0d exp ovr=1 writes=0", ovr_cnt, we_addr_q.size()); end
  endtask

  task automatic test_reset_mid_read();
    bit seen;
    clear_logs();
    regs[64] = 8'h66; regs[1] = 8'h5C;
    tx_halt = 1'b1;
    ss_low();
    send_word(8'hC0);
    cycles(3);
    n_checks++; if (busy !== 1'b1 || reg_addr !== 7'h40) begin
      n_fail++; $display("FAIL rst_pre got busy=%b addr=%h exp busy=1 addr=40", busy, reg_addr); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || reg_addr !== 7'h00 || reg_re !== 1'b0 || tx_wr !== 1'b0 || tx_data !== 8'h00) begin
      n_fail++; $display("FAIL rst_async got busy=%b addr=%h re=%b txwr=%b tx=%h exp all 0", busy, reg_addr, reg_re, tx_wr, tx_data); end
    @(posedge clk); #1 rst = 1'b1;
    tx_halt = 1'b0;
    clear_logs();
    ss_high();
    ss_low();
    send_word(8'h81);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (tx_wr) seen = 1'b1;
    end
    n_checks++; if (!seen || tx_data !== 8'h5C) begin
      n_fail++; $display("FAIL rst_reread got seen=%b data=%h exp seen=1 data=5C", seen, tx_data); end
    n_checks++; if (re_addr_q.size() < 1 || re_addr_q[0] !== 7'h01) begin
      n_fail++; $display("FAIL rst_reread_addr got count=%0d exp first addr=01", re_addr_q.size()); end
    ss_high();
  endtask

  task automatic test_invariants();
    n_checks++; if (viol != 0) begin n_fail++; $display("FAIL invariants got=%0d exp=0", viol); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) regs[i] = 8'h00;
    reg_rdata = 8'h00;
    test_reset();
    test_write_burst();
    test_read_burst();
    test_wrap();
    test_abort();
    test_overrun_halt();
    test_reset_mid_read();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
